// File: rtl/pc_pkg.sv
// Shared op encoding for the program counter / return-stack block.
package pc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    PC_NEXT   = 3'd0,
    PC_JUMP   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4
  } op_t;

endpackage

// File: rtl/program_counter_stack_return_stack.sv
// Parametrised LIFO of return addresses; only the fill count is reset.
module return_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [DW-1:0] cnt;
  logic [AW-1:0] top_idx;

  assign full    = (cnt == DW'(DEPTH));
  assign empty   = (cnt == '0);
  assign top_idx = AW'(cnt - DW'(1));
  assign top     = empty ? '0 : mem[top_idx];
  assign depth   = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + DW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - DW'(1);
    end
  end

  // Storage is deliberately left uncleared; an empty stack reads 0 via top.
  always_ff @(posedge clk) begin
    if (rst_n && push && !full) begin
      mem[cnt[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with next-PC mux and a bounded return-address stack.
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               stall,
  input  logic [OP_W-1:0]                    op,
  input  logic [ADDR_W-1:0]                  target,
  input  logic [ADDR_W-1:0]                  offset,
  output logic [ADDR_W-1:0]                  pc,
  output logic [ADDR_W-1:0]                  ret_addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               ovf,
  output logic                               unf
);

  localparam int DW = $clog2(STACK_DEPTH + 1);

  op_t               op_e;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;
  logic              full;
  logic              empty;

  assign op_e   = op_t'(op);
  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op_e)
      PC_NEXT:   pc_next = pc_inc;
      PC_JUMP:   pc_next = target;
      PC_BRANCH: pc_next = pc + offset;
      PC_CALL: begin
        pc_next = target;
        if (full) ovf_set = 1'b1;
        else      push    = 1'b1;
      end
      PC_RET: begin
        // Returning from an empty stack degrades to a plain NEXT.
        if (empty) begin
          pc_next = pc_inc;
          unf_set = 1'b1;
        end else begin
          pc_next = ret_addr;
          pop     = 1'b1;
        end
      end
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc  <= RESET_VEC;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (!stall) begin
      pc  <= pc_next;
      ovf <= ovf | ovf_set;
      unf <= unf | unf_set;
    end
  end

  return_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH),
    .DW    (DW)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push && !stall),
    .pop       (pop && !stall),
    .push_data (pc_inc),
    .top       (ret_addr),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed-vector bench for program_counter_stack with default parameters.
module tb_program_counter_stack;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] op = 3'd5;
  logic [7:0] target = 8'h00;
  logic [7:0] offset = 8'h00;
  logic [7:0] pc;
  logic [7:0] ret_addr;
  logic [2:0] depth;
  logic       ovf;
  logic       unf;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BRANCH = 3'd2, CALL = 3'd3, RET = 3'd4, HOLD = 3'd5;

  program_counter_stack dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .op       (op),
    .target   (target),
    .offset   (offset),
    .pc       (pc),
    .ret_addr (ret_addr),
    .depth    (depth),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [7:0] t, input logic [7:0] f);
    op = o; target = t; offset = f;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; op = HOLD;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = CALL; target = 8'h77;
    step();
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", pc); end
    checks++; if (depth !== 3'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", depth); end
    checks++; if (ret_addr !== 8'h00) begin failures++; $display("FAIL reset_ret got=%h exp=00", ret_addr); end
    checks++; if ({ovf, unf} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {ovf, unf}); end
    rst_n = 1'b1;
  endtask

  task automatic test_next_count();
    do_reset();
    checks++; if (pc !== 8'd0) begin failures++; $display("FAIL count_start got=%0d exp=0", pc); end
    for (int i = 1; i <= 10; i++) begin
      do_op(NEXT, 8'h00, 8'h00);
      checks++; if (pc !== 8'(i)) begin failures++; $display("FAIL count_%0d got=%0d exp=%0d", i, pc, i); end
    end
  endtask

  task automatic test_wrap();
    do_op(JUMP, 8'hFF, 8'h00);
    checks++; if (pc !== 8'hFF) begin failures++; $display("FAIL jump_ff got=%h exp=ff", pc); end
    do_op(NEXT, 8'h00, 8'h00);
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL next_wrap got=%h exp=00", pc); end
    do_op(JUMP, 8'h02, 8'h00);
    do_op(BRANCH, 8'h00, 8'hFC);
    checks++; if (pc !== 8'hFE) begin failures++; $display("FAIL branch_back got=%h exp=fe", pc); end
    do_op(BRANCH, 8'h00, 8'h05);
    checks++; if (pc !== 8'h03) begin failures++; $display("FAIL branch_fwd_wrap got=%h exp=03", pc); end
    do_op(HOLD, 8'h00, 8'h00);
    checks++; if (pc !== 8'h03) begin failures++; $display("FAIL hold got=%h exp=03", pc); end
  endtask

  task automatic test_call_ret();
    do_op(JUMP, 8'h10, 8'h00);
    do_op(CALL, 8'h40, 8'h00);
    checks++; if (pc !== 8'h40) begin failures++; $display("FAIL call_pc got=%h exp=40", pc); end
    checks++; if (depth !== 3'd1) begin failures++; $display("FAIL call_depth got=%0d exp=1", depth); end
    checks++; if (ret_addr !== 8'h11) begin failures++; $display("FAIL call_ret got=%h exp=11", ret_addr); end
    do_op(RET, 8'h00, 8'h00);
    checks++; if (pc !== 8'h11) begin failures++; $display("FAIL ret_pc got=%h exp=11", pc); end
    checks++; if (depth !== 3'd0) begin failures++; $display("FAIL ret_depth got=%0d exp=0", depth); end
    checks++; if (ret_addr !== 8'h00) begin failures++; $display("FAIL ret_empty_top got=%h exp=00", ret_addr); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_ret [4];
    exp_ret[0] = 8'h71; exp_ret[1] = 8'h61; exp_ret[2] = 8'h51; exp_ret[3] = 8'h31;
    do_reset();
    do_op(JUMP, 8'h30, 8'h00);
    do_op(CALL, 8'h50, 8'h00);
    do_op(CALL, 8'h60, 8'h00);
    do_op(CALL, 8'h70, 8'h00);
    do_op(CALL, 8'h80, 8'h00);
    checks++; if (depth !== 3'd4 || ovf !== 1'b0) begin failures++; $display("FAIL full_no_ovf got=%0d/%b exp=4/0", depth, ovf); end
    do_op(CALL, 8'h90, 8'h00);
    checks++; if (pc !== 8'h90) begin failures++; $display("FAIL ovf_pc got=%h exp=90", pc); end
    checks++; if (depth !== 3'd4 || ovf !== 1'b1) begin failures++; $display("FAIL ovf_state got=%0d/%b exp=4/1", depth, ovf); end
    checks++; if (ret_addr !== 8'h71) begin failures++; $display("FAIL ovf_top got=%h exp=71", ret_addr); end
    for (int i = 0; i < 4; i++) begin
      do_op(RET, 8'h00, 8'h00);
      checks++; if (pc !== exp_ret[i]) begin failures++; $display("FAIL lifo_%0d got=%h exp=%h", i, pc, exp_ret[i]); end
      checks++; if (depth !== 3'(3 - i)) begin failures++; $display("FAIL lifo_depth_%0d got=%0d exp=%0d", i, depth, 3 - i); end
    end
    checks++; if (ovf !== 1'b1 || unf !== 1'b0) begin failures++; $display("FAIL ovf_sticky got=%b%b exp=10", ovf, unf); end
  endtask

  task automatic test_underflow();
    do_reset();
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", ovf); end
    do_op(JUMP, 8'h20, 8'h00);
    do_op(RET, 8'h00, 8'h00);
    checks++; if (pc !== 8'h21) begin failures++; $display("FAIL unf_pc got=%h exp=21", pc); end
    checks++; if (unf !== 1'b1 || depth !== 3'd0) begin failures++; $display("FAIL unf_state got=%b/%0d exp=1/0", unf, depth); end
    for (int i = 0; i < 20; i++) do_op(i % 2 == 0 ? HOLD : JUMP, 8'h21, 8'h00);
    checks++; if (unf !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%b exp=1", unf); end
    checks++; if (pc !== 8'h21) begin failures++; $display("FAIL unf_hold_pc got=%h exp=21", pc); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    do_op(JUMP, 8'h10, 8'h00);
    do_op(CALL, 8'h40, 8'h00);
    do_op(CALL, 8'h50, 8'h00);
    checks++; if (pc !== 8'h50 || depth !== 3'd2) begin failures++; $display("FAIL pre_stall got=%h/%0d exp=50/2", pc, depth); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) do_op(CALL, 8'h70, 8'h00);
    checks++; if (pc !== 8'h50 || depth !== 3'd2) begin failures++; $display("FAIL stall_call got=%h/%0d exp=50/2", pc, depth); end
    checks++; if (ret_addr !== 8'h41) begin failures++; $display("FAIL stall_top got=%h exp=41", ret_addr); end
    do_op(RET, 8'h00, 8'h00);
    checks++; if (pc !== 8'h50 || depth !== 3'd2) begin failures++; $display("FAIL stall_ret got=%h/%0d exp=50/2", pc, depth); end
    stall = 1'b0;
    rst_n = 1'b0; op = CALL; target = 8'h70;
    step();
    rst_n = 1'b1;
    checks++; if (pc !== 8'h00 || depth !== 3'd0) begin failures++; $display("FAIL mid_reset got=%h/%0d exp=00/0", pc, depth); end
    checks++; if ({ovf, unf} !== 2'b00 || ret_addr !== 8'h00) begin failures++; $display("FAIL mid_reset_flags got=%b/%h exp=00/00", {ovf, unf}, ret_addr); end
    do_op(RET, 8'h00, 8'h00);
    checks++; if (pc !== 8'h01 || unf !== 1'b1) begin failures++; $display("FAIL discarded got=%h/%b exp=01/1", pc, unf); end
  endtask

  initial begin
    test_reset();
    test_next_count();
    test_wrap();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
